// File: rtl/normal_isect_unit_p.sv
// Triangle normal (V2-V1)x(V3-V1) and hit point start+t*dir on one shared multiplier.
// Optional face-forward (dot test plus FLIP state) is enabled by NORMAL_FACEFWD_EN.
module normal_isect_unit_p #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3*WIDTH-1:0]   trig_v1,
    input  logic [3*WIDTH-1:0]   trig_v2,
    input  logic [3*WIDTH-1:0]   trig_v3,
    input  logic [3*WIDTH-1:0]   ray_start,
    input  logic [3*WIDTH-1:0]   ray_dir,
    input  logic [WIDTH-1:0]     t,
    output logic                 ready,
    output logic [3*WIDTH-1:0]   normal,
    output logic [3*WIDTH-1:0]   isect_point,
    output logic                 ovf,
    output logic                 flipped
);

    localparam int PW = 2 * WIDTH;
    localparam int LW = 2 * WIDTH + 2;
`ifdef NORMAL_FACEFWD_EN
    localparam logic [3:0] LAST = 4'd11;
`else
    localparam logic [3:0] LAST = 4'd8;
`endif

    typedef logic signed [WIDTH-1:0] scalar_t;
    typedef logic signed [LW-1:0]    wide_t;
    typedef enum logic [2:0] {StIdle, StLoad, StMul, StFlip, StDone} state_t;

    // Returns {saturated, value}.
    function automatic logic [WIDTH:0] sat(input wide_t v);
        wide_t maxv;
        wide_t minv;
        maxv = wide_t'({{(LW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
        minv = ~maxv;
        if (v > maxv)      sat = {1'b1, maxv[WIDTH-1:0]};
        else if (v < minv) sat = {1'b1, minv[WIDTH-1:0]};
        else               sat = {1'b0, v[WIDTH-1:0]};
    endfunction

    function automatic scalar_t comp(input logic [3*WIDTH-1:0] v, input int i);
        comp = v[(2-i)*WIDTH +: WIDTH];
    endfunction

    state_t                  state_q;
    logic [3:0]              step_q, pstep_q;
    logic                    pvalid_q;
    logic signed [PW-1:0]    prod_q, prod;
    scalar_t                 e1_q [3], e2_q [3], st_q [3], dir_q [3], n_q [3], p_q [3];
    scalar_t                 t_q;
    wide_t                   term_q;

    scalar_t                 mul_a, mul_b;
    scalar_t                 e1_in [3], e2_in [3], n_nxt [3], p_nxt [3];
    logic [WIDTH:0]          ld1 [3], ld2 [3];
    logic                    e_ovf, ovf_nxt;
    wide_t                   term_nxt, prod_ext, diff;
    logic [WIDTH:0]          r1, r2;
    logic [1:0]              pidx;

    always_comb begin
        e_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld1[i]   = sat(LW'(comp(trig_v2, i)) - LW'(comp(trig_v1, i)));
            ld2[i]   = sat(LW'(comp(trig_v3, i)) - LW'(comp(trig_v1, i)));
            e1_in[i] = ld1[i][WIDTH-1:0];
            e2_in[i] = ld2[i][WIDTH-1:0];
            e_ovf    = e_ovf | ld1[i][WIDTH] | ld2[i][WIDTH];
        end
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_q)
            4'd0: begin mul_a = e1_q[1]; mul_b = e2_q[2]; end
            4'd1: begin mul_a = e1_q[2]; mul_b = e2_q[1]; end
            4'd2: begin mul_a = e1_q[2]; mul_b = e2_q[0]; end
            4'd3: begin mul_a = e1_q[0]; mul_b = e2_q[2]; end
            4'd4: begin mul_a = e1_q[0]; mul_b = e2_q[1]; end
            4'd5: begin mul_a = e1_q[1]; mul_b = e2_q[0]; end
            4'd6: begin mul_a = t_q;     mul_b = dir_q[0]; end
            4'd7: begin mul_a = t_q;     mul_b = dir_q[1]; end
            4'd8: begin mul_a = t_q;     mul_b = dir_q[2]; end
`ifdef NORMAL_FACEFWD_EN
            4'd9:  begin mul_a = n_q[0]; mul_b = dir_q[0]; end
            4'd10: begin mul_a = n_q[1]; mul_b = dir_q[1]; end
            4'd11: begin mul_a = n_q[2]; mul_b = dir_q[2]; end
`endif
            default: ;
        endcase
        prod = PW'(mul_a) * PW'(mul_b);
    end

`ifdef NORMAL_FACEFWD_EN
    wide_t          dot_q, dot_nxt;
    logic           flipped_q;
    logic [WIDTH:0] neg [3];
    logic           neg_ovf;

    assign flipped = flipped_q;

    always_comb begin
        neg_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg[i]  = sat(-(LW'(n_q[i])));
            neg_ovf = neg_ovf | neg[i][WIDTH];
        end
    end
`else
    assign flipped = 1'b0;
`endif

    // Consumes the product registered on the previous MUL cycle.
    always_comb begin
        n_nxt    = n_q;
        p_nxt    = p_q;
        term_nxt = term_q;
        ovf_nxt  = ovf;
        prod_ext = LW'(prod_q);
        diff     = '0;
        r1       = '0;
        r2       = '0;
        pidx     = pstep_q[1:0] + 2'd2;  // maps steps 6/7/8 to components 0/1/2
`ifdef NORMAL_FACEFWD_EN
        dot_nxt  = dot_q;
`endif
        if (state_q == StMul && pvalid_q) begin
            case (pstep_q)
                4'd0, 4'd2, 4'd4: term_nxt = prod_ext;
                4'd1, 4'd3, 4'd5: begin
                    diff                = term_q - prod_ext;
                    r1                  = sat(diff >>> FRAC);
                    n_nxt[pstep_q[2:1]] = r1[WIDTH-1:0];
                    ovf_nxt             = ovf | r1[WIDTH];
                end
                4'd6, 4'd7, 4'd8: begin
                    r1          = sat(prod_ext >>> FRAC);
                    r2          = sat(LW'(st_q[pidx]) + LW'(scalar_t'(r1[WIDTH-1:0])));
                    p_nxt[pidx] = r2[WIDTH-1:0];
                    ovf_nxt     = ovf | r1[WIDTH] | r2[WIDTH];
                end
`ifdef NORMAL_FACEFWD_EN
                4'd9:         dot_nxt = prod_ext;
                4'd10, 4'd11: dot_nxt = dot_q + prod_ext;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            step_q      <= '0;
            pstep_q     <= '0;
            pvalid_q    <= 1'b0;
            prod_q      <= '0;
            term_q      <= '0;
            t_q         <= '0;
            e1_q        <= '{default: '0};
            e2_q        <= '{default: '0};
            st_q        <= '{default: '0};
            dir_q       <= '{default: '0};
            n_q         <= '{default: '0};
            p_q         <= '{default: '0};
            ready       <= 1'b0;
            normal      <= '0;
            isect_point <= '0;
            ovf         <= 1'b0;
`ifdef NORMAL_FACEFWD_EN
            dot_q       <= '0;
            flipped_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: if (start) state_q <= StLoad;
                StLoad: begin
                    e1_q     <= e1_in;
                    e2_q     <= e2_in;
                    t_q      <= t;
                    for (int i = 0; i < 3; i++) begin
                        st_q[i]  <= comp(ray_start, i);
                        dir_q[i] <= comp(ray_dir, i);
                    end
                    ovf      <= e_ovf;
                    step_q   <= '0;
                    pvalid_q <= 1'b0;
                    state_q  <= StMul;
                end
                StMul: begin
                    n_q    <= n_nxt;
                    p_q    <= p_nxt;
                    term_q <= term_nxt;
                    ovf    <= ovf_nxt;
`ifdef NORMAL_FACEFWD_EN
                    dot_q  <= dot_nxt;
`endif
                    if (step_q <= LAST) begin
                        prod_q   <= prod;
                        pstep_q  <= step_q;
                        pvalid_q <= 1'b1;
                        step_q   <= step_q + 4'd1;
                    end else begin
                        pvalid_q <= 1'b0;
`ifdef NORMAL_FACEFWD_EN
                        state_q  <= StFlip;
`else
                        state_q     <= StDone;
                        ready       <= 1'b1;
                        normal      <= {n_nxt[0], n_nxt[1], n_nxt[2]};
                        isect_point <= {p_nxt[0], p_nxt[1], p_nxt[2]};
`endif
                    end
                end
`ifdef NORMAL_FACEFWD_EN
                StFlip: begin
                    state_q     <= StDone;
                    ready       <= 1'b1;
                    isect_point <= {p_q[0], p_q[1], p_q[2]};
                    if (!dot_q[LW-1] && dot_q != '0) begin
                        normal    <= {neg[0][WIDTH-1:0], neg[1][WIDTH-1:0], neg[2][WIDTH-1:0]};
                        flipped_q <= 1'b1;
                        ovf       <= ovf | neg_ovf;
                    end else begin
                        normal    <= {n_q[0], n_q[1], n_q[2]};
                        flipped_q <= 1'b0;
                    end
                end
`endif
                StDone: begin
                    if (start) begin
                        state_q <= StLoad;
                        ready   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_normal_isect_unit_p.sv
// Directed self-checking bench for normal_isect_unit_p at WIDTH=32, FRAC=16.
module tb_normal_isect_unit_p;

    localparam int W = 32;
`ifdef NORMAL_FACEFWD_EN
    localparam int LAT = 15;
`else
    localparam int LAT = 11;
`endif

    logic           clock = 1'b0;
    logic           reset, start;
    logic [3*W-1:0] trig_v1, trig_v2, trig_v3, ray_start, ray_dir;
    logic [W-1:0]   t;
    logic           ready, ovf, flipped;
    logic [3*W-1:0] normal, isect_point;

    int checks = 0;
    int errors = 0;

    // Expected results for the reference triangle
    localparam logic [3*W-1:0] N_REF = {32'h0, 32'h0, 32'h00040000};
    localparam logic [3*W-1:0] P_REF = {32'h00018000, 32'h00008000, 32'h00008000};

    always #5 clock = ~clock;

    normal_isect_unit_p #(.WIDTH(W), .FRAC(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .trig_v1     (trig_v1),
        .trig_v2     (trig_v2),
        .trig_v3     (trig_v3),
        .ray_start   (ray_start),
        .ray_dir     (ray_dir),
        .t           (t),
        .ready       (ready),
        .normal      (normal),
        .isect_point (isect_point),
        .ovf         (ovf),
        .flipped     (flipped)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [3*W-1:0] v2, input logic [3*W-1:0] v3,
                          input logic [3*W-1:0] s, input logic [3*W-1:0] d,
                          input logic [W-1:0] tt);
        trig_v1   = '0;
        trig_v2   = v2;
        trig_v3   = v3;
        ray_start = s;
        ray_dir   = d;
        t         = tt;
    endtask

    task automatic ref_inputs;
        set_in({32'h00020000, 32'h0, 32'h0}, {32'h0, 32'h00020000, 32'h0},
               {32'hFFFF8000, 32'h00008000, 32'h00008000}, {32'h00010000, 32'h0, 32'h0},
               32'h00020000);
    endtask

    // Pulses start and counts cycles until ready; capped at 40.
    task automatic run_op(output int lat);
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 0;
        while (!ready && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        ref_inputs();
        tick;
        tick;
        reset = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++;
        if (normal !== '0) begin errors++; $display("FAIL reset_normal got %h want 0", normal); end
        checks++;
        if (isect_point !== '0) begin
            errors++; $display("FAIL reset_isect got %h want 0", isect_point);
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++;
        if (flipped !== 1'b0) begin errors++; $display("FAIL reset_flipped got %b want 0", flipped); end
    endtask

    task automatic test_basic;
        int lat;
        ref_inputs();
        run_op(lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
        checks++;
        if (normal !== N_REF) begin errors++; $display("FAIL basic_normal got %h want %h", normal, N_REF); end
        checks++;
        if (isect_point !== P_REF) begin
            errors++; $display("FAIL basic_isect got %h want %h", isect_point, P_REF);
        end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", ovf); end
        checks++;
        if (flipped !== 1'b0) begin errors++; $display("FAIL basic_flipped got %b want 0", flipped); end
    endtask

    task automatic test_saturation;
        int lat;
        logic [3*W-1:0] exp_p;
        exp_p = {32'h7FFFFFFF, 32'h00008000, 32'h00008000};
        set_in({32'h00020000, 32'h0, 32'h0}, {32'h0, 32'h00020000, 32'h0},
               {32'h00008000, 32'h00008000, 32'h00008000}, {32'h00020000, 32'h0, 32'h0},
               32'h7FFF0000);
        run_op(lat);
        checks++;
        if (isect_point !== exp_p) begin
            errors++; $display("FAIL sat_isect got %h want %h", isect_point, exp_p);
        end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", ovf); end
        checks++;
        if (normal !== N_REF) begin errors++; $display("FAIL sat_normal got %h want %h", normal, N_REF); end
        ref_inputs();
        run_op(lat);
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear got %b want 0", ovf); end
        checks++;
        if (isect_point !== P_REF) begin
            errors++; $display("FAIL sat_next_isect got %h want %h", isect_point, P_REF);
        end
    endtask

    task automatic test_mid_reset;
        int lat;
        ref_inputs();
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", ready); end
        checks++;
        if (normal !== '0 || isect_point !== '0) begin
            errors++; $display("FAIL midrst_outputs got %h %h want 0 0", normal, isect_point);
        end
        checks++;
        if (ovf !== 1'b0 || flipped !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got %b%b want 00", ovf, flipped);
        end
        for (int i = 0; i < 4; i++) tick;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL midrst_discard got %b want 0", ready); end
        run_op(lat);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, LAT); end
        checks++;
        if (normal !== N_REF || isect_point !== P_REF) begin
            errors++; $display("FAIL midrst_result got %h %h want %h %h",
                               normal, isect_point, N_REF, P_REF);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        ref_inputs();
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        trig_v2 = {32'h0, 32'h0, 32'h00020000};
        tick;
        tick;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        lat = 5;
        while (!ready && lat < 40) begin
            tick;
            lat++;
        end
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, LAT); end
        checks++;
        if (normal !== N_REF) begin errors++; $display("FAIL ignore_normal got %h want %h", normal, N_REF); end
        checks++;
        if (isect_point !== P_REF) begin
            errors++; $display("FAIL ignore_isect got %h want %h", isect_point, P_REF);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [3*W-1:0] exp_n, exp_p;
        exp_n = {32'h0, 32'hFFFC0000, 32'h0};
        exp_p = {32'h0, 32'h00030000, 32'h0};
        ref_inputs();
        run_op(lat);
        set_in({32'h00020000, 32'h0, 32'h0}, {32'h0, 32'h0, 32'h00020000},
               '0, {32'h0, 32'h00010000, 32'h0}, 32'h00030000);
        start = 1'b1;
        tick;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", ready); end
        lat = 0;
        while (!ready && lat < 40) begin
            tick;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", lat, LAT); end
        checks++;
        if (normal !== exp_n) begin errors++; $display("FAIL b2b_normal got %h want %h", normal, exp_n); end
        checks++;
        if (isect_point !== exp_p) begin
            errors++; $display("FAIL b2b_isect got %h want %h", isect_point, exp_p);
        end
        tick;
    endtask

`ifdef NORMAL_FACEFWD_EN
    task automatic test_facefwd;
        int lat;
        ref_inputs();
        ray_dir = {32'h0, 32'h0, 32'h00010000};
        run_op(lat);
        checks++;
        if (lat !== 15) begin errors++; $display("FAIL ff_latency got %0d want 15", lat); end
        checks++;
        if (normal !== {32'h0, 32'h0, 32'hFFFC0000}) begin
            errors++; $display("FAIL ff_normal got %h want z=fffc0000", normal);
        end
        checks++;
        if (flipped !== 1'b1) begin errors++; $display("FAIL ff_flipped got %b want 1", flipped); end
        ray_dir = {32'h0, 32'h0, 32'hFFFF0000};
        run_op(lat);
        checks++;
        if (normal !== N_REF) begin errors++; $display("FAIL ff_keep_normal got %h want %h", normal, N_REF); end
        checks++;
        if (flipped !== 1'b0) begin errors++; $display("FAIL ff_keep_flipped got %b want 0", flipped); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_mid_reset();
        test_ignore_start();
        test_back_to_back();
`ifdef NORMAL_FACEFWD_EN
        test_facefwd();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
